fetch_sequencer: RTL

Instruction fetch and issue sequencer that drives the CPU controller's instruction bus.
- Holds the program counter and reads 16-bit instruction words from a synchronous instruction ROM.
- Issues each word to the controller as a one-cycle valid pulse.
- Paces issue so the controller is never handed an instruction while a LOAD or JUMP is still in flight.
- Accepts the controller's set-address (jump target) output to redirect the PC.

---
 rtl/fetch_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch/issue sequencer; optional single-step via FETCH_SINGLE_STEP_EN
package fetch_seq_pkg;
    // Opcodes live in instruction bits [15:8]; shared with the controller
    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_LOAD = 8'h02;
    localparam logic [7:0] OP_JUMP = 8'h03;
endpackage

module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int                ADDR_W       = 8,
    parameter int                INSTR_W      = 16,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int                ROM_LATENCY  = 1,
    parameter int                LOAD_HOLD    = 3,
    parameter int                JUMP_TIMEOUT = 4
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_enable,
`ifdef FETCH_SINGLE_STEP_EN
    input  logic               i_step_mode,
    input  logic               i_step,
`endif
    output logic               o_rom_rd,
    output logic [ADDR_W-1:0]  o_rom_addr,
    input  logic [INSTR_W-1:0] i_rom_data,
    output logic               o_instruction_valid,
    output logic [INSTR_W-1:0] o_instruction,
    input  logic               i_set_address_valid,
    input  logic [ADDR_W-1:0]  i_set_address,
    output logic [ADDR_W-1:0]  o_pc,
    output logic               o_busy,
    output logic               o_jump_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_MEM,
        S_ISSUE,
        S_HOLD,
        S_JUMP_WAIT
    } state_t;

    // One shared down-counter serves ROM wait, LOAD hold and JUMP timeout
    localparam int CNT_W = 8;

    state_t             state, state_next;
    logic [ADDR_W-1:0]  pc, pc_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [INSTR_W-1:0] ir, ir_next;
    logic               jump_to, jump_to_next;
    logic               start_ok;
    logic [7:0]         opcode;

    assign opcode = ir[INSTR_W-1:INSTR_W-8];

`ifdef FETCH_SINGLE_STEP_EN
    // In step mode each i_step seen in IDLE releases exactly one instruction
    assign start_ok = i_enable && (!i_step_mode || i_step);
`else
    assign start_ok = i_enable;
`endif

    // State register; reset drops any in-flight fetch or issue immediately
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers: PC, wait counter, instruction register, sticky timeout
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pc      <= RESET_VECTOR;
            cnt     <= '0;
            ir      <= '0;
            jump_to <= 1'b0;
        end else begin
            pc      <= pc_next;
            cnt     <= cnt_next;
            ir      <= ir_next;
            jump_to <= jump_to_next;
        end
    end

    // Next-state and datapath updates; Moore outputs decoded from the registered state
    always_comb begin
        state_next          = state;
        pc_next             = pc;
        cnt_next            = cnt;
        ir_next             = ir;
        jump_to_next        = jump_to;
        o_rom_rd            = 1'b0;
        o_rom_addr          = '0;
        o_instruction_valid = 1'b0;
        o_instruction       = '0;
        o_busy              = (state != S_IDLE);

        unique case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                o_rom_rd   = 1'b1;
                o_rom_addr = pc;
                cnt_next   = CNT_W'(ROM_LATENCY);
                state_next = S_WAIT_MEM;
            end
            S_WAIT_MEM: begin
                if (cnt <= CNT_W'(1)) begin
                    ir_next    = i_rom_data;
                    state_next = S_ISSUE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            S_ISSUE: begin
                o_instruction_valid = 1'b1;
                o_instruction       = ir;
                pc_next             = pc + ADDR_W'(1);
                if (opcode == OP_LOAD) begin
                    cnt_next   = CNT_W'(LOAD_HOLD);
                    state_next = (LOAD_HOLD == 0) ? S_IDLE : S_HOLD;
                end else if (opcode == OP_JUMP) begin
                    cnt_next   = CNT_W'(JUMP_TIMEOUT);
                    state_next = S_JUMP_WAIT;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_HOLD: begin
                if (cnt <= CNT_W'(1)) begin
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            S_JUMP_WAIT: begin
                // A target arriving on the expiry cycle still wins over the timeout
                if (i_set_address_valid) begin
                    pc_next    = i_set_address;
                    state_next = S_IDLE;
                end else if (cnt <= CNT_W'(1)) begin
                    jump_to_next = 1'b1;
                    state_next   = S_IDLE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign o_pc           = pc;
    assign o_jump_timeout = jump_to;

endmodule
